// File: rtl/traffic_light_adaptive.sv
// Adaptive two-way traffic light controller with pedestrian latches and night mode.
// Lights are decoded (Moore) from the state register; sensor inputs are used as sampled.
module traffic_light_adaptive #(
  parameter int CNT_W     = 5,
  parameter int GREEN_MIN = 12,
  parameter int GREEN_MAX = 24,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SA,
  input  logic       SB,
  input  logic       PRA,
  input  logic       PRB,
  input  logic       NIGHT,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] PA,
  output logic [1:0] PB,
  output logic [2:0] STATE,
  output logic [1:0] PED_WAIT
);

  typedef enum logic [2:0] {
    S_AG  = 3'b000,
    S_AY  = 3'b001,
    S_AR1 = 3'b010,
    S_BG  = 3'b011,
    S_BY  = 3'b100,
    S_AR2 = 3'b101,
    S_NT  = 3'b110,
    S_BAD = 3'b111
  } state_t;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_BLINK  = 2'b11;

  // Thresholds are "last cycle" values: the timer reads 0 on the first cycle of a state.
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_req_a;
  logic             r_req_b;

  logic w_a_go;
  logic w_b_go;
  logic w_yel_done;
  logic w_ar_done;
  logic w_timer_sat;

  assign w_timer_sat = (r_timer == {CNT_W{1'b1}});
  assign w_yel_done  = (r_timer >= YEL_LAST);
  assign w_ar_done   = (r_timer >= ALLRED_LAST);

  // A green ends once minimum time is served and B wants the road, unless A still has
  // traffic, in which case it runs on until the maximum.
  assign w_a_go = (r_timer >= GMIN_LAST) && (SB || r_req_a || NIGHT) &&
                  (!SA || (r_timer >= GMAX_LAST));
  assign w_b_go = (r_timer >= GMIN_LAST) && (SA || r_req_b || NIGHT) &&
                  (!SB || (r_timer >= GMAX_LAST));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_AG;
      r_timer <= '0;
      r_req_a <= 1'b0;
      r_req_b <= 1'b0;
    end else begin
      if (!w_timer_sat) begin
        r_timer <= r_timer + CNT_W'(1);
      end
      if (PRA && (r_state != S_BG)) begin
        r_req_a <= 1'b1;
      end
      if (PRB && (r_state != S_AG)) begin
        r_req_b <= 1'b1;
      end
      // Every branch that changes state also zeroes the timer; later NBAs win.
      case (r_state)
        S_AG: begin
          if (w_a_go) begin
            r_state <= S_AY;
            r_timer <= '0;
          end
        end
        S_AY: begin
          if (w_yel_done) begin
            r_state <= S_AR1;
            r_timer <= '0;
          end
        end
        S_AR1: begin
          if (w_ar_done) begin
            r_timer <= '0;
            if (NIGHT) begin
              r_state <= S_NT;
            end else begin
              r_state <= S_BG;
              r_req_a <= 1'b0;
            end
          end
        end
        S_BG: begin
          if (w_b_go) begin
            r_state <= S_BY;
            r_timer <= '0;
          end
        end
        S_BY: begin
          if (w_yel_done) begin
            r_state <= S_AR2;
            r_timer <= '0;
          end
        end
        S_AR2: begin
          if (w_ar_done) begin
            r_timer <= '0;
            if (NIGHT) begin
              r_state <= S_NT;
            end else begin
              r_state <= S_AG;
              r_req_b <= 1'b0;
            end
          end
        end
        S_NT: begin
          if (!NIGHT) begin
            r_state <= S_AR2;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= S_AG;
          r_timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    A  = L_RED;
    B  = L_RED;
    PA = L_RED;
    PB = L_RED;
    case (r_state)
      S_AG: begin
        A  = L_GREEN;
        PB = L_GREEN;
      end
      S_AY: begin
        A  = L_YELLOW;
        PB = L_BLINK;
      end
      S_BG: begin
        B  = L_GREEN;
        PA = L_GREEN;
      end
      S_BY: begin
        B  = L_YELLOW;
        PA = L_BLINK;
      end
      S_NT: begin
        A  = L_YELLOW;
        B  = L_BLINK;
        PA = L_BLINK;
        PB = L_BLINK;
      end
      default: begin
        A  = L_RED;
        B  = L_RED;
      end
    endcase
  end

  assign STATE    = r_state;
  assign PED_WAIT = {r_req_b, r_req_a};

endmodule
